// File: rtl/token_packet_decoder.sv
// token_packet_decoder: decodes USB token/handshake/data packet headers from an unstuffed byte stream
//   clk48, rst_n                  : clock, asynchronous active-low reset
//   rxValid, rxData, rxIsLast     : received byte, qualified by rxValid; rxIsLast marks the byte before EOP
//   ownAddr                       : device address used for pktAddrMatch
//   pktValid                      : one-cycle pulse, result fields valid (they hold until the next pulse)
//   pktPid/Addr/Endpt/FrameNum    : decoded fields, zero where not applicable to the PID class
//   pktAddrMatch, pktErr          : token address hit, {errLen, errCrc, errPid}
module token_packet_decoder #(
    parameter int CRC_CHECK = 1
) (
    input  logic        clk48,
    input  logic        rst_n,
    input  logic        rxValid,
    input  logic [7:0]  rxData,
    input  logic        rxIsLast,
    input  logic [6:0]  ownAddr,
    output logic        pktValid,
    output logic [3:0]  pktPid,
    output logic [6:0]  pktAddr,
    output logic [3:0]  pktEndpt,
    output logic [10:0] pktFrameNum,
    output logic        pktAddrMatch,
    output logic [2:0]  pktErr
);
    typedef enum logic [1:0] {IDLE, TOK1, TOK2, SKIP} state_t;

    state_t      state_q;
    logic [3:0]  pid_q;
    logic [7:0]  byte1_q;
    logic [4:0]  crc_q;
    logic [2:0]  pend_q;
    logic        valid_q;
    logic [3:0]  out_pid_q;
    logic [6:0]  addr_q;
    logic [3:0]  endp_q;
    logic [10:0] frame_q;
    logic        match_q;
    logic [2:0]  err_q;

    logic        pid_bad;
    logic [4:0]  crc_d;
    logic [10:0] fld;
    logic        is_sof;
    logic        crc_bad;
    logic        emit;
    logic [3:0]  e_pid;
    logic [6:0]  e_addr;
    logic [3:0]  e_endp;
    logic [10:0] e_frame;
    logic        e_match;
    logic [2:0]  e_err;

    // Eight steps of the serial CRC5 (LSb first) so a whole byte is absorbed per cycle
    function automatic logic [4:0] crc5_byte(input logic [4:0] c_in, input logic [7:0] d);
        logic [4:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++)
            c = {c[3:0], 1'b0} ^ ((d[i] ^ c[4]) ? 5'b00101 : 5'b00000);
        return c;
    endfunction

    assign pid_bad = (rxData[7:4] != ~rxData[3:0]) || (rxData[1:0] == 2'b00);
    assign crc_d   = crc5_byte(crc_q, rxData);
    assign fld     = {rxData[2:0], byte1_q};
    assign is_sof  = pid_q == 4'b0101;
    assign crc_bad = (CRC_CHECK != 0) && (crc_d != 5'b01100);

    always_comb begin
        emit    = rxValid && rxIsLast;
        e_pid   = state_q == IDLE ? rxData[3:0] : pid_q;
        e_addr  = 7'd0;
        e_endp  = 4'd0;
        e_frame = 11'd0;
        e_match = 1'b0;
        e_err   = pend_q;
        case (state_q)
            IDLE: e_err = pid_bad ? 3'b001 : (rxData[1:0] == 2'b10 ? 3'b000 : 3'b100);
            TOK1: e_err = 3'b100;
            TOK2: begin
                e_err   = {1'b0, crc_bad, 1'b0};
                e_addr  = is_sof ? 7'd0 : fld[6:0];
                e_endp  = is_sof ? 4'd0 : fld[10:7];
                e_frame = is_sof ? fld : 11'd0;
                e_match = !is_sof && (fld[6:0] == ownAddr || fld[6:0] == 7'd0);
            end
            SKIP: e_err = pend_q;
        endcase
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pid_q     <= 4'd0;
            byte1_q   <= 8'd0;
            crc_q     <= 5'h1f;
            pend_q    <= 3'd0;
            valid_q   <= 1'b0;
            out_pid_q <= 4'd0;
            addr_q    <= 7'd0;
            endp_q    <= 4'd0;
            frame_q   <= 11'd0;
            match_q   <= 1'b0;
            err_q     <= 3'd0;
        end else begin
            valid_q <= emit;
            if (emit) begin
                out_pid_q <= e_pid;
                addr_q    <= e_addr;
                endp_q    <= e_endp;
                frame_q   <= e_frame;
                match_q   <= e_match;
                err_q     <= e_err;
            end
            if (rxValid) begin
                case (state_q)
                    IDLE: begin
                        pid_q  <= rxData[3:0];
                        crc_q  <= 5'h1f;
                        // result carried to the final byte when this packet is not a token
                        pend_q <= pid_bad ? 3'b001 : (rxData[1:0] == 2'b11 ? 3'b000 : 3'b100);
                        if (!rxIsLast)
                            state_q <= (!pid_bad && rxData[1:0] == 2'b01) ? TOK1 : SKIP;
                    end
                    TOK1: begin
                        byte1_q <= rxData;
                        crc_q   <= crc_d;
                        state_q <= rxIsLast ? IDLE : TOK2;
                    end
                    TOK2: begin
                        crc_q   <= crc_d;
                        pend_q  <= 3'b100;
                        state_q <= rxIsLast ? IDLE : SKIP;
                    end
                    SKIP: if (rxIsLast) state_q <= IDLE;
                endcase
            end
        end
    end

    assign pktValid     = valid_q;
    assign pktPid       = out_pid_q;
    assign pktAddr      = addr_q;
    assign pktEndpt     = endp_q;
    assign pktFrameNum  = frame_q;
    assign pktAddrMatch = match_q;
    assign pktErr       = err_q;
endmodule

// File: tb/tb_token_packet_decoder.sv
// tb_token_packet_decoder: directed self-checking bench for token_packet_decoder
module tb_token_packet_decoder;
    logic        clk48 = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_is_last;
    logic [6:0]  own_addr;
    logic        pkt_valid, pkt_addr_match, nc_valid, nc_match;
    logic [3:0]  pkt_pid, pkt_endpt, nc_pid, nc_endpt;
    logic [6:0]  pkt_addr, nc_addr;
    logic [10:0] pkt_frame, nc_frame;
    logic [2:0]  pkt_err, nc_err;
    int          vectors = 0;
    int          errors = 0;
    int          vcount = 0;
    int          snap;
    logic [7:0]  b2;

    token_packet_decoder #(.CRC_CHECK(1)) u_dut (
        .clk48(clk48), .rst_n(rst_n), .rxValid(rx_valid), .rxData(rx_data), .rxIsLast(rx_is_last),
        .ownAddr(own_addr), .pktValid(pkt_valid), .pktPid(pkt_pid), .pktAddr(pkt_addr),
        .pktEndpt(pkt_endpt), .pktFrameNum(pkt_frame), .pktAddrMatch(pkt_addr_match), .pktErr(pkt_err)
    );

    token_packet_decoder #(.CRC_CHECK(0)) u_nocrc (
        .clk48(clk48), .rst_n(rst_n), .rxValid(rx_valid), .rxData(rx_data), .rxIsLast(rx_is_last),
        .ownAddr(own_addr), .pktValid(nc_valid), .pktPid(nc_pid), .pktAddr(nc_addr),
        .pktEndpt(nc_endpt), .pktFrameNum(nc_frame), .pktAddrMatch(nc_match), .pktErr(nc_err)
    );

    always #5 clk48 = ~clk48;

    always @(negedge clk48) if (pkt_valid === 1'b1) vcount++;

    function automatic logic [4:0] crc_bits(input logic [15:0] bits);
        logic [4:0] c;
        logic       fb;
        c = 5'b11111;
        for (int i = 0; i < 16; i++) begin
            fb = bits[i] ^ c[4];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    // byte 2 whose CRC field makes {byte2, byte1} leave the good residual
    function automatic logic [7:0] make_b2(input logic [7:0] b1, input logic [2:0] lo);
        logic [7:0] r;
        r = {5'd0, lo};
        for (int k = 0; k < 32; k++)
            if (crc_bits({k[4:0], lo, b1}) == 5'b01100) r = {k[4:0], lo};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic last);
        @(negedge clk48);
        rx_valid   = 1'b1;
        rx_data    = d;
        rx_is_last = last;
        @(negedge clk48);
        rx_valid   = 1'b0;
        rx_is_last = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_is_last = 1'b0; own_addr = 7'h15;
        repeat (2) @(negedge clk48);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_pid", pkt_pid, 0);
        chk("rst_addr", pkt_addr, 0);
        chk("rst_endp", pkt_endpt, 0);
        chk("rst_frame", pkt_frame, 0);
        chk("rst_match", pkt_addr_match, 0);
        chk("rst_err", pkt_err, 0);
        rst_n = 1'b1;

        b2 = make_b2(8'h15, 3'b111);
        put(8'hE1, 1'b0);
        put(8'h15, 1'b0);
        rx_is_last = 1'b1;
        @(negedge clk48);
        rx_is_last = 1'b0;
        chk("out_nolast_valid", pkt_valid, 0);
        put(b2, 1'b1);
        chk("out_valid", pkt_valid, 1);
        chk("out_pid", pkt_pid, 4'h1);
        chk("out_addr", pkt_addr, 7'h15);
        chk("out_endp", pkt_endpt, 4'hE);
        chk("out_match", pkt_addr_match, 1);
        chk("out_err", pkt_err, 3'b000);
        chk("out_frame", pkt_frame, 0);
        @(negedge clk48);
        chk("out_pulse", pkt_valid, 0);
        chk("out_hold", pkt_addr, 7'h15);

        put(8'hE1, 1'b0);
        put(8'h11, 1'b0);
        put(b2, 1'b1);
        chk("crc_bad_err", pkt_err, 3'b010);
        chk("crc_off_err", nc_err, 3'b000);
        chk("crc_off_valid", nc_valid, 1);

        put(8'hD2, 1'b1);
        chk("ack_valid", pkt_valid, 1);
        chk("ack_pid", pkt_pid, 4'h2);
        chk("ack_err", pkt_err, 3'b000);
        chk("ack_addr", pkt_addr, 0);
        chk("ack_match", pkt_addr_match, 0);
        put(8'hD3, 1'b1);
        chk("badpid_err", pkt_err, 3'b001);

        put(8'hA5, 1'b0);
        put(8'h34, 1'b0);
        put(8'h77, 1'b0);
        chk("sof_long_early", pkt_valid, 0);
        put(8'h05, 1'b1);
        chk("sof_long_valid", pkt_valid, 1);
        chk("sof_long_err", pkt_err, 3'b100);
        chk("sof_long_pid", pkt_pid, 4'h5);

        put(8'h69, 1'b0);
        put(8'h00, 1'b1);
        chk("in_short_valid", pkt_valid, 1);
        chk("in_short_err", pkt_err, 3'b100);
        chk("in_short_pid", pkt_pid, 4'h9);

        b2 = make_b2(8'h34, 3'b010);
        put(8'hA5, 1'b0);
        put(8'h34, 1'b0);
        put(b2, 1'b1);
        chk("sof_frame", pkt_frame, 11'h234);
        chk("sof_addr", pkt_addr, 0);
        chk("sof_match", pkt_addr_match, 0);
        chk("sof_err", pkt_err, 3'b000);

        b2 = make_b2(8'h80, 3'b000);
        put(8'hE1, 1'b0);
        put(8'h80, 1'b0);
        put(b2, 1'b1);
        chk("addr0_addr", pkt_addr, 0);
        chk("addr0_endp", pkt_endpt, 4'h1);
        chk("addr0_match", pkt_addr_match, 1);

        @(negedge clk48);
        snap = vcount;
        put(8'hC3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk48);
            put(8'($urandom), i == 9);
        end
        chk("data_pid", pkt_pid, 4'h3);
        chk("data_err", pkt_err, 3'b000);
        @(negedge clk48);
        chk("data_once", vcount - snap, 1);

        @(negedge clk48);
        rx_valid = 1'b1; rx_data = 8'hD2; rx_is_last = 1'b1;
        @(negedge clk48);
        chk("b2b_first_pid", pkt_pid, 4'h2);
        rx_data = 8'hD3;
        @(negedge clk48);
        rx_valid = 1'b0; rx_is_last = 1'b0;
        chk("b2b_second_valid", pkt_valid, 1);
        chk("b2b_second_pid", pkt_pid, 4'h3);
        chk("b2b_second_err", pkt_err, 3'b001);

        @(negedge clk48);
        snap = vcount;
        put(8'hE1, 1'b0);
        put(8'h15, 1'b0);
        rst_n = 1'b0;
        @(negedge clk48);
        chk("midrst_valid", pkt_valid, 0);
        chk("midrst_pid", pkt_pid, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk48);
        chk("midrst_none", vcount - snap, 0);
        put(8'hD2, 1'b1);
        chk("postrst_valid", pkt_valid, 1);
        chk("postrst_pid", pkt_pid, 4'h2);
        chk("postrst_err", pkt_err, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/token_packet_decoder.md
TOKEN_PACKET_DECODER -- requirements
Module: token_packet_decoder

Interface
REQ-001 SHALL have parameter CRC_CHECK, default 1, meaning: 1 = CRC5 errors are flagged; 0 = the CRC5 error flag is forced to 0.
REQ-002 SHALL have port clk48  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rxValid  input  1  rxData holds a received byte this cycle (sync stripped, unstuffed, LSb = first bit on wire).
REQ-005 SHALL have port rxData  input  8  received byte.
REQ-006 SHALL have port rxIsLast  input  1  qualifies rxValid: this byte is the last before EOP.
REQ-007 SHALL have port ownAddr  input  7  current device address.
REQ-008 SHALL have port pktValid  output  1  one-cycle pulse: a packet was decoded and its result fields are valid.
REQ-009 SHALL have port pktPid  output  4  PID[3:0] of the decoded packet.
REQ-010 SHALL have port pktAddr  output  7  token address field.
REQ-011 SHALL have port pktEndpt  output  4  token endpoint field.
REQ-012 SHALL have port pktFrameNum  output  11  SOF frame number.
REQ-013 SHALL have port pktAddrMatch  output  1  token pktAddr equals ownAddr, or pktAddr equals 0.
REQ-014 SHALL have port pktErr  output  3  {errLen, errCrc, errPid}, valid with pktValid.

Function
REQ-015 Byte 0 SHALL be the PID byte; errPid SHALL be set if rxData[7:4] != ~rxData[3:0], or if PID[1:0] == 00 (special/reserved).
REQ-016 The FSM SHALL have states IDLE, TOK1, TOK2, SKIP.
REQ-017 IDLE with rxValid and rxIsLast SHALL emit a result and stay in IDLE; handshake PIDs (x10) SHALL be error-free; any other PID class SHALL set errLen, except that errPid has priority and suppresses errLen.
REQ-018 IDLE with rxValid, not rxIsLast:
- token PID (x01, errPid clear) -> TOK1;
- data PID (x11) -> SKIP, no error;
- handshake, special or errPid -> SKIP; the later result SHALL carry errLen (handshake) or errPid.
REQ-019 TOK1 SHALL latch byte 1 and go to TOK2; if rxIsLast, it SHALL emit errLen and go to IDLE.
REQ-020 TOK2 SHALL latch byte 2; with rxIsLast it SHALL emit the result and go to IDLE; without rxIsLast it SHALL go to SKIP with errLen pending.
REQ-021 SKIP SHALL discard bytes until rxValid and rxIsLast, then emit the pending result and go to IDLE; for data PIDs, pktErr SHALL be 0.
REQ-022 Field layout: f[10:0] = {byte2[2:0], byte1}.
- pktAddr = f[6:0], pktEndpt = f[10:7];
- pktFrameNum = f when the PID is SOF (0101), otherwise 0;
- CRC5 field = byte2[7:3], bit 3 = CRC MSb.
REQ-023 CRC5 SHALL be computed serially over all 16 bits of bytes 1..2 in wire order (byte1 bit0 first), covering the 11 field bits then the 5 CRC bits.
- init 5'b11111;
- per bit b: fb = b ^ c[4]; c = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 0);
- errCrc = (c != 5'b01100) when CRC_CHECK = 1.
- The implementation MAY process 8 bits per cycle; the result SHALL equal the serial definition.
REQ-024 pktValid SHALL assert exactly one cycle after the rxValid cycle carrying rxIsLast.
REQ-025 Result fields SHALL be registered and SHALL hold until the next pktValid.
REQ-026 Cycles with rxValid = 0 SHALL never change the FSM state; gaps between bytes SHALL be tolerated.
REQ-027 rxIsLast without rxValid SHALL be ignored.
REQ-028 Fields not applicable to the PID class SHALL be driven 0 with pktValid, and pktAddrMatch SHALL be 0 for non-token packets.
REQ-029 Throughput: a new PID byte SHALL be accepted in IDLE on the same cycle pktValid of the previous packet is high.

Reset
REQ-030 While rst_n = 0, the FSM SHALL be IDLE and all outputs SHALL be 0, including pktValid, pktPid, pktAddr, pktEndpt, pktFrameNum, pktAddrMatch and pktErr.
REQ-031 The CRC register SHALL be 5'b11111 in reset and SHALL be re-initialised on every PID byte.
REQ-032 Reset asserted mid-packet SHALL abandon the packet with no pktValid; after release, the first valid byte SHALL be treated as a PID byte.

Verification
REQ-033 Bytes E1, 15, EF with the last flag on EF (OUT token, addr 0x15, endp 0xE), ownAddr = 0x15 -> one cycle later: pktValid = 1, pktPid = 0001, pktAddr = 15, pktEndpt = E, pktAddrMatch = 1, pktErr = 000; the CRC field is generated by the bench serial model.
REQ-034 The same token with byte1 bit 2 flipped -> pktErr = 010; repeat with CRC_CHECK = 0 -> pktErr = 000.
REQ-035 Single byte D2 with last (ACK) -> pktValid, pktPid = 0010, pktErr = 000; single byte D3 with last (bad complement) -> pktErr = 001.
REQ-036 Bytes A5, 34, x, 5 with last on the fourth byte (SOF, overlong) -> pktErr = 100, emitted only after the fourth byte; bytes 69, 00 with last (truncated IN) -> pktErr = 100.
REQ-037 C3 followed by 10 data bytes with random rxValid gaps, last on the final byte -> exactly one pktValid, pktPid = 0011, pktErr = 000.
REQ-038 rst_n pulsed low after E1, 15 -> no pktValid; a following D2 with last decodes as ACK.
